// File: rtl/axis_gen_pkg.sv
// Shared descriptor layout, FSM states and TDATA packing for the AXIS traffic path.
package axis_gen_pkg;

  localparam int LEN_LSB   = 0;
  localparam int LEN_W     = 16;
  localparam int PAUSE_LSB = 16;
  localparam int PAUSE_W   = 32;
  localparam int CH_LSB    = 48;

  // Fixed-width part of a descriptor; the channel field sits above it at
  // CH_LSB and its width follows the ID_WIDTH parameter of the user.
  typedef struct packed {
    logic [PAUSE_W-1:0] pause;
    logic [LEN_W-1:0]   length;
  } desc_body_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Low 32 bits of a beat: packet sequence number over beat index.
  function automatic logic [31:0] pack_tdata(input logic [15:0] seq,
                                             input logic [15:0] beat);
    return {seq, beat};
  endfunction

endpackage

// File: rtl/axis_packet_former.sv
// Turns {channel, pause, length} descriptors into AXI-Stream packets, with an
// idle gap of `pause` cycles after each packet.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | descriptor_ready_o high, waiting for a descriptor
// ST_SEND  | driving beats of the current packet on m_axis
// ST_PAUSE | output idle, counting down the inter-packet gap
module axis_packet_former
  import axis_gen_pkg::*;
#(
  parameter int ID_WIDTH   = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cntrl_stop_i,
  input  logic [47+ID_WIDTH:0]   descriptor_data_i,
  input  logic                   descriptor_valid_i,
  output logic                   descriptor_ready_o,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata_o,
  output logic [ID_WIDTH-1:0]    m_axis_tid_o,
  output logic                   m_axis_tlast_o,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i,
  output logic                   busy_o,
  output logic [31:0]            pkt_cnt_o,
  output logic                   drop_pulse_o
);

  state_t                state_q;
  logic                  rst_done_q;
  logic [15:0]           len_q;
  logic [31:0]           pause_q;
  logic [ID_WIDTH-1:0]   ch_q;
  logic [15:0]           beat_q;
  logic [15:0]           seq_q;
  logic [31:0]           pause_cnt_q;
  logic [31:0]           pkt_cnt_q;
  logic                  drop_q;

  desc_body_t            desc_body;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] tdata_w;

  assign desc_body = descriptor_data_i[CH_LSB-1:LEN_LSB];
  assign last_beat = (beat_q == len_q - 16'd1);

  // Descriptor intake, beat/sequence/packet counters and the pause down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rst_done_q  <= 1'b0;
      len_q       <= '0;
      pause_q     <= '0;
      ch_q        <= '0;
      beat_q      <= '0;
      seq_q       <= '0;
      pause_cnt_q <= '0;
      pkt_cnt_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      drop_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (descriptor_valid_i && rst_done_q) begin
            len_q   <= desc_body.length;
            pause_q <= desc_body.pause;
            ch_q    <= descriptor_data_i[CH_LSB +: ID_WIDTH];
            beat_q  <= '0;
            if (desc_body.length != 16'd0) begin
              state_q <= ST_SEND;
            end else begin
              drop_q <= 1'b1;
              if (desc_body.pause != 32'd0) begin
                state_q     <= ST_PAUSE;
                pause_cnt_q <= desc_body.pause;
              end
            end
          end
        end
        ST_SEND: begin
          if (m_axis_tready_i) begin
            beat_q <= beat_q + 16'd1;
            if (last_beat) begin
              pkt_cnt_q <= pkt_cnt_q + 32'd1;
              seq_q     <= seq_q + 16'd1;
              // A stop request skips the gap but never cuts the packet short.
              if (cntrl_stop_i || pause_q == 32'd0) begin
                state_q <= ST_IDLE;
              end else begin
                state_q     <= ST_PAUSE;
                pause_cnt_q <= pause_q;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (cntrl_stop_i || pause_cnt_q == 32'd1) begin
            state_q <= ST_IDLE;
          end else begin
            pause_cnt_q <= pause_cnt_q - 32'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Beat payload, zero outside SEND and above bit 31.
  always_comb begin
    tdata_w = '0;
    if (state_q == ST_SEND) tdata_w[31:0] = pack_tdata(seq_q, beat_q);
  end

  assign descriptor_ready_o = (state_q == ST_IDLE) && rst_done_q;
  assign m_axis_tvalid_o    = (state_q == ST_SEND);
  assign m_axis_tlast_o     = (state_q == ST_SEND) && last_beat;
  assign m_axis_tid_o       = ch_q;
  assign m_axis_tdata_o     = tdata_w;
  assign busy_o             = (state_q != ST_IDLE);
  assign pkt_cnt_o          = pkt_cnt_q;
  assign drop_pulse_o       = drop_q;

endmodule

// File: tb/tb_axis_packet_former.sv
// Scoreboard bench for axis_packet_former: expected beats are queued when a
// descriptor is accepted and compared as beats are handshaken.
module tb_axis_packet_former;

  localparam int IDW = 10;
  localparam int DW  = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cntrl_stop_i;
  logic [47+IDW:0] descriptor_data_i;
  logic            descriptor_valid_i;
  logic            descriptor_ready_o;
  logic [DW-1:0]   m_axis_tdata_o;
  logic [IDW-1:0]  m_axis_tid_o;
  logic            m_axis_tlast_o;
  logic            m_axis_tvalid_o;
  logic            m_axis_tready_i;
  logic            busy_o;
  logic [31:0]     pkt_cnt_o;
  logic            drop_pulse_o;

  axis_packet_former #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cntrl_stop_i       (cntrl_stop_i),
    .descriptor_data_i  (descriptor_data_i),
    .descriptor_valid_i (descriptor_valid_i),
    .descriptor_ready_o (descriptor_ready_o),
    .m_axis_tdata_o     (m_axis_tdata_o),
    .m_axis_tid_o       (m_axis_tid_o),
    .m_axis_tlast_o     (m_axis_tlast_o),
    .m_axis_tvalid_o    (m_axis_tvalid_o),
    .m_axis_tready_i    (m_axis_tready_i),
    .busy_o             (busy_o),
    .pkt_cnt_o          (pkt_cnt_o),
    .drop_pulse_o       (drop_pulse_o)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [42:0] exp_q[$];
  logic [15:0] seq_exp = 16'd0;
  int          cyc_n = 0;
  logic        drop_exp = 1'b0;
  logic        prev_v = 1'b0, prev_rdy = 1'b0, prev_last_hs = 1'b0;
  logic [42:0] prev_bus = '0;
  logic        desc_hs, beat_hs, last_hs;
  int          last_desc_cyc, last_tlast_cyc, pkt_beats, hs_a, hs_b, n_hs;
  logic [42:0] exp_beat;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
  endtask

  function automatic logic [57:0] mk_desc(input logic [9:0] ch, input logic [31:0] pause,
                                          input logic [15:0] len);
    return {ch, pause, len};
  endfunction

  // One clock: drive inputs at the falling edge, then account for what the
  // next rising edge will see.
  task automatic cyc(input logic rdy, input logic dv, input logic [57:0] dd);
    logic [42:0] bus;
    logic [15:0] len;
    @(negedge clk);
    m_axis_tready_i    = rdy;
    descriptor_valid_i = dv;
    descriptor_data_i  = dd;
    cyc_n++;
    bus = {m_axis_tlast_o, m_axis_tid_o, m_axis_tdata_o};
    if (reset_n) begin
      check_val("drop_pulse", 64'(drop_pulse_o), 64'(drop_exp));
      if (prev_v && !prev_last_hs) check_val("tvalid_hold", 64'(m_axis_tvalid_o), 64'd1);
      if (prev_v && !prev_rdy) check_val("stall_stable", 64'(bus), 64'(prev_bus));
    end
    drop_exp = 1'b0;
    desc_hs = dv && descriptor_ready_o;
    beat_hs = m_axis_tvalid_o && rdy;
    last_hs = beat_hs && m_axis_tlast_o;
    if (desc_hs) begin
      last_desc_cyc = cyc_n;
      n_hs++;
      len = dd[15:0];
      if (len == 16'd0) drop_exp = 1'b1;
      else begin
        for (int i = 0; i < int'(len); i++)
          exp_q.push_back({(i == int'(len) - 1), dd[57:48], seq_exp, 16'(i)});
        seq_exp++;
      end
    end
    if (beat_hs) begin
      pkt_beats++;
      if (exp_q.size() == 0) check_val("unexpected_beat", 64'(bus), 64'd0);
      else begin
        exp_beat = exp_q.pop_front();
        check_val("beat", 64'(bus), 64'(exp_beat));
      end
      if (m_axis_tlast_o) last_tlast_cyc = cyc_n;
    end
    prev_v       = m_axis_tvalid_o && reset_n;
    prev_rdy     = rdy;
    prev_last_hs = last_hs;
    prev_bus     = bus;
  endtask

  task automatic send_desc(input logic [57:0] dd);
    int k;
    k = 0;
    do begin
      cyc(1'b1, 1'b1, dd);
      k++;
    end while (!desc_hs && k < 50);
    if (!desc_hs) check_val("desc_timeout", 64'd0, 64'd1);
  endtask

  // Run with tready following a 4-entry pattern until the tlast handshake.
  task automatic run_to_tlast(input logic [3:0] pat);
    int k;
    k = 0;
    pkt_beats = 0;
    do begin
      cyc(pat[k % 4], 1'b0, '0);
      k++;
    end while (!last_hs && k < 500);
    if (!last_hs) check_val("tlast_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    do begin
      cyc(1'b1, 1'b0, '0);
      k++;
    end while (!descriptor_ready_o && k < 500);
    if (!descriptor_ready_o) check_val("ready_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; cntrl_stop_i = 1'b0; descriptor_valid_i = 1'b0;
    descriptor_data_i = '0; m_axis_tready_i = 1'b0; n_hs = 0; pkt_beats = 0;
    last_desc_cyc = 0; last_tlast_cyc = 0;
    #1;
    check_val("rst_ready",  64'(descriptor_ready_o), 64'd0);
    check_val("rst_tvalid", 64'(m_axis_tvalid_o), 64'd0);
    check_val("rst_busy",   64'(busy_o), 64'd0);
    check_val("rst_pkt",    64'(pkt_cnt_o), 64'd0);
    check_val("rst_tdata",  64'(m_axis_tdata_o), 64'd0);
    repeat (3) cyc(1'b0, 1'b0, '0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    check_val("idle_ready", 64'(descriptor_ready_o), 64'd1);
    check_val("idle_busy",  64'(busy_o), 64'd0);

    // Basic packet with a 3-cycle gap.
    send_desc(mk_desc(10'd5, 32'd3, 16'd4));
    cyc(1'b1, 1'b0, '0);
    check_val("first_valid_lat", 64'(m_axis_tvalid_o), 64'd1);
    run_to_tlast(4'b1111);
    check_val("t1_beats", 64'(pkt_beats + 1), 64'd4);
    wait_ready();
    check_val("t1_ready_gap", 64'(cyc_n - last_tlast_cyc), 64'd4);
    check_val("t1_pkt_cnt", 64'(pkt_cnt_o), 64'd1);

    // Same descriptor with back-pressure 1-0-0-1.
    send_desc(mk_desc(10'd5, 32'd3, 16'd4));
    run_to_tlast(4'b1001);
    check_val("t2_beats", 64'(pkt_beats), 64'd4);
    wait_ready();
    check_val("t2_pkt_cnt", 64'(pkt_cnt_o), 64'd2);

    // Two single-beat packets, descriptor held valid.
    n_hs = 0; hs_a = 0; hs_b = 0;
    for (int k = 0; k < 20 && n_hs < 2; k++) begin
      cyc(1'b1, 1'b1, mk_desc(10'd9, 32'd0, 16'd1));
      if (desc_hs && n_hs == 1) hs_a = cyc_n;
      if (desc_hs && n_hs == 2) hs_b = cyc_n;
    end
    repeat (3) cyc(1'b1, 1'b0, '0);
    check_val("t3_hs_spacing", 64'(hs_b - hs_a), 64'd2);
    check_val("t3_pkt_cnt", 64'(pkt_cnt_o), 64'd4);
    check_val("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length descriptor: drop pulse and a 2-cycle gap only.
    send_desc(mk_desc(10'd1, 32'd2, 16'd0));
    cyc(1'b1, 1'b0, '0);
    check_val("t4_drop", 64'(drop_pulse_o), 64'd1);
    check_val("t4_no_valid", 64'(m_axis_tvalid_o), 64'd0);
    wait_ready();
    check_val("t4_ready_gap", 64'(cyc_n - last_desc_cyc), 64'd3);
    check_val("t4_pkt_cnt", 64'(pkt_cnt_o), 64'd4);

    // Graceful stop raised at beat 1 of a long-pause packet.
    send_desc(mk_desc(10'd2, 32'd100, 16'd6));
    pkt_beats = 0;
    for (int k = 0; k < 100; k++) begin
      cntrl_stop_i = (pkt_beats >= 1);
      cyc(1'b1, 1'b0, '0);
      if (last_hs) break;
    end
    check_val("t5_beats", 64'(pkt_beats), 64'd6);
    cyc(1'b1, 1'b0, '0);
    cntrl_stop_i = 1'b0;
    check_val("t5_ready_next", 64'(descriptor_ready_o), 64'd1);
    check_val("t5_busy", 64'(busy_o), 64'd0);
    check_val("t5_pkt_cnt", 64'(pkt_cnt_o), 64'd5);

    // Asynchronous reset in the middle of an 8-beat packet.
    send_desc(mk_desc(10'd3, 32'd0, 16'd8));
    pkt_beats = 0;
    for (int k = 0; k < 50 && pkt_beats < 2; k++) cyc(1'b1, 1'b0, '0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("t6_tvalid", 64'(m_axis_tvalid_o), 64'd0);
    check_val("t6_tlast",  64'(m_axis_tlast_o), 64'd0);
    check_val("t6_busy",   64'(busy_o), 64'd0);
    check_val("t6_ready",  64'(descriptor_ready_o), 64'd0);
    exp_q.delete();
    seq_exp = 16'd0; drop_exp = 1'b0; prev_v = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, '0);
    reset_n = 1'b1;
    wait_ready();
    check_val("t6_ready_after", 64'(descriptor_ready_o), 64'd1);
    send_desc(mk_desc(10'd7, 32'd0, 16'd2));
    run_to_tlast(4'b1111);
    wait_ready();
    check_val("t6_pkt_cnt", 64'(pkt_cnt_o), 64'd1);
    check_val("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
